uart_rx_core: RTL and testbench

Synthesizable, parametrised UART receiver for the SoC peripheral bus. It oversamples a serial line with a programmable baud divider and supports runtime-selectable data bits, parity and stop bits. Received characters and their per-character error flags are buffered in an internal FIFO behind a valid/ready handshake. A sticky overrun flag records characters lost to a full FIFO.

---
 rtl/uart_pkg.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_core.sv | 272 +++++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART receiver:
//     uart_rx_state_e : receiver FSM states
//     uart_parity_e   : runtime parity selection (0/3 = none, 1 = even, 2 = odd)
//     uart_err_t      : per-character error flags {brk, frm, par}
//     DBITS_*         : data-bits encoding of i_cfg_dbits
//     dbits_last_idx  : index of the final data bit for a dbits code
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_DATA     = 3'd2,
      ST_PARITY   = 3'd3,
      ST_STOP     = 3'd4,
      ST_BRK_WAIT = 3'd5
   } uart_rx_state_e;

   typedef enum logic [1:0] {
      PAR_NONE     = 2'd0,
      PAR_EVEN     = 2'd1,
      PAR_ODD      = 2'd2,
      PAR_NONE_ALT = 2'd3
   } uart_parity_e;

   typedef struct packed {
      logic brk;
      logic frm;
      logic par;
   } uart_err_t;

   localparam logic [1:0] DBITS_5 = 2'd0;
   localparam logic [1:0] DBITS_6 = 2'd1;
   localparam logic [1:0] DBITS_7 = 2'd2;
   localparam logic [1:0] DBITS_8 = 2'd3;

   localparam int UART_RX_ENTRY_W = 11;  // {err[2:0], data[7:0]}

   function automatic logic [2:0] dbits_last_idx(input logic [1:0] dbits);
      logic [2:0] idx;
      case (dbits)
         DBITS_5: idx = 3'd4;
         DBITS_6: idx = 3'd5;
         DBITS_7: idx = 3'd6;
         DBITS_8: idx = 3'd7;
         default: idx = 3'd7;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Synchronous FIFO holding received characters plus their error flags.
//   Pointers carry one extra wrap bit so full/empty are unambiguous.
//   A push while full is accepted only if a pop happens in the same cycle
//   (the slot being vacated is the one being written).
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_push, i_wdata   write request and entry
//   i_pop             read request (ignored when empty)
//   o_rdata           head entry (combinational read of registered storage)
//   o_full, o_empty   status
//   o_level           occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign o_empty = (wr_ptr_q == rd_ptr_q);
   assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign o_level = wr_ptr_q - rd_ptr_q;
   assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = i_pop & ~o_empty;
   assign do_push = i_push & (~o_full | do_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage needs no reset; the consumer gates the head with empty.
   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   Oversampling UART receiver with runtime data-bits / parity / stop-bits
//   selection, break detection, an RX FIFO behind a valid/ready handshake and
//   a sticky overrun flag.
// Ports:
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_rx_en                    receiver enable (deassert aborts a frame)
//   i_baud_div                 one oversample tick every i_baud_div+1 clocks
//   i_cfg_dbits/parity/stop2   frame format, captured when data bits begin
//   i_uart_rx                  asynchronous serial line, idle high
//   o_data, o_err, o_valid     FIFO head (zeroed while empty)
//   i_ready                    pop when o_valid & i_ready
//   o_level                    FIFO occupancy
//   o_overrun, i_overrun_clr   sticky character-dropped flag and its clear
//   o_busy                     FSM not idle
// -----------------------------------------------------------------------------
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int OVS        = 16,
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_rx_en,
   input  logic [DIV_W-1:0]                i_baud_div,
   input  logic [1:0]                      i_cfg_dbits,
   input  logic [1:0]                      i_cfg_parity,
   input  logic                            i_cfg_stop2,
   input  logic                            i_uart_rx,
   output logic [7:0]                      o_data,
   output logic [2:0]                      o_err,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level,
   output logic                            o_overrun,
   input  logic                            i_overrun_clr,
   output logic                            o_busy
);

   localparam int PH_W  = $clog2(OVS);
   localparam int LVL_W = $clog2(FIFO_DEPTH+1);
   // Sample phases around mid-bit; the bit is resolved on the last of them.
   localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVS/2 - 1);
   localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVS/2);
   localparam logic [PH_W-1:0] PH_RES  = PH_W'(OVS/2 + 1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);

   // ---------------------------------------------------------------- sync
   logic sync1_q, rx_s, rx_prev_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_q   <= 1'b1;
         rx_s      <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= i_uart_rx;
         rx_s      <= sync1_q;
         rx_prev_q <= rx_s;
      end
   end

   // ---------------------------------------------------------------- ticks
   logic [DIV_W-1:0] tick_cnt_q;
   logic             tick;

   assign tick = i_rx_en && (tick_cnt_q == '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                   tick_cnt_q <= '0;
      else if (!i_rx_en || tick)   tick_cnt_q <= i_baud_div;
      else                         tick_cnt_q <= tick_cnt_q - DIV_W'(1);
   end

   // ---------------------------------------------------------------- FSM state
   uart_rx_state_e state_q, state_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic            samp0_q, samp1_q;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic            stop_cnt_q, stop_cnt_d;
   logic [7:0]      data_q, data_d;
   logic            par_err_q, par_err_d;
   logic            par_bit_q, par_bit_d;
   logic [1:0]      dbits_q, dbits_d;
   uart_parity_e    parity_q, parity_d;
   logic            stop2_q, stop2_d;
   logic            push_q, push_d;
   logic [7:0]      push_data_q, push_data_d;
   uart_err_t       push_err_q, push_err_d;

   logic resolve, maj, par_en, par_exp;

   assign resolve = tick && (phase_q == PH_RES);
   assign maj     = (samp0_q & samp1_q) | (samp0_q & rx_s) | (samp1_q & rx_s);
   assign par_en  = (parity_q == PAR_EVEN) || (parity_q == PAR_ODD);
   assign par_exp = (^data_q) ^ (parity_q == PAR_ODD);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         samp0_q <= 1'b1;
         samp1_q <= 1'b1;
      end else begin
         if (tick && phase_q == PH_S0) samp0_q <= rx_s;
         if (tick && phase_q == PH_S1) samp1_q <= rx_s;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= 1'b0;
         data_q      <= '0;
         par_err_q   <= 1'b0;
         par_bit_q   <= 1'b0;
         dbits_q     <= DBITS_8;
         parity_q    <= PAR_NONE;
         stop2_q     <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         push_err_q  <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         data_q      <= data_d;
         par_err_q   <= par_err_d;
         par_bit_q   <= par_bit_d;
         dbits_q     <= dbits_d;
         parity_q    <= parity_d;
         stop2_q     <= stop2_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         push_err_q  <= push_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      data_d      = data_q;
      par_err_d   = par_err_q;
      par_bit_d   = par_bit_q;
      dbits_d     = dbits_q;
      parity_d    = parity_q;
      stop2_d     = stop2_q;
      push_d      = 1'b0;
      push_data_d = data_q;
      push_err_d  = '0;

      if (tick) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);

      case (state_q)
         ST_IDLE: begin
            // Edge-detect so a line stuck low never retriggers.
            if (i_rx_en && rx_prev_q && !rx_s) begin
               state_d = ST_START;
               phase_d = '0;
            end
         end
         ST_START: begin
            if (resolve && maj) begin
               state_d = ST_IDLE;                // glitch, not a start bit
            end else if (tick && phase_q == PH_LAST) begin
               state_d   = ST_DATA;
               dbits_d   = i_cfg_dbits;
               parity_d  = uart_parity_e'(i_cfg_parity);
               stop2_d   = i_cfg_stop2;
               data_d    = '0;
               bit_cnt_d = '0;
               par_err_d = 1'b0;
               par_bit_d = 1'b0;
            end
         end
         ST_DATA: begin
            if (resolve) begin
               data_d[bit_cnt_q] = maj;          // LSB first, MSBs stay 0
               if (bit_cnt_q == dbits_last_idx(dbits_q)) begin
                  state_d    = par_en ? ST_PARITY : ST_STOP;
                  stop_cnt_d = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (resolve) begin
               par_bit_d = maj;
               par_err_d = (maj != par_exp);
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (resolve) begin
               if (!maj && !stop_cnt_q && data_q == '0 && !(par_en && par_bit_q)) begin
                  // Break: whole character time low through the first stop bit.
                  push_d         = 1'b1;
                  push_err_d.brk = 1'b1;
                  push_err_d.frm = 1'b1;
                  push_err_d.par = par_err_q;
                  state_d        = ST_BRK_WAIT;
               end else if (!maj || stop_cnt_q == stop2_q) begin
                  // Push on the last stop bit, or early on a bad one.
                  push_d         = 1'b1;
                  push_err_d.frm = !maj;
                  push_err_d.par = par_err_q;
                  state_d        = ST_IDLE;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         ST_BRK_WAIT: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (!i_rx_en) begin
         state_d = ST_IDLE;
         push_d  = 1'b0;
      end
   end

   assign o_busy = (state_q != ST_IDLE);

   // ---------------------------------------------------------------- FIFO
   logic [UART_RX_ENTRY_W-1:0] fifo_rdata;
   logic                       fifo_full, fifo_empty, pop, drop, overrun_q, overrun_d;
   logic [LVL_W-1:0]           fifo_level;

   assign pop  = o_valid & i_ready;
   assign drop = push_q & fifo_full & ~pop;

   uart_rx_fifo #(
      .WIDTH (UART_RX_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push_q),
      .i_wdata ({push_err_q, push_data_q}),
      .i_pop   (pop),
      .o_rdata (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_level (fifo_level)
   );

   assign o_valid = ~fifo_empty;
   assign o_level = fifo_level;
   assign o_data  = fifo_empty ? 8'h00 : fifo_rdata[7:0];
   assign o_err   = fifo_empty ? 3'b000 : fifo_rdata[10:8];

   // A set in the same cycle as a clear wins.
   assign overrun_d = drop | (overrun_q & ~i_overrun_clr);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) overrun_q <= 1'b0;
      else       overrun_q <= overrun_d;
   end

   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;
   localparam int OVS   = 16;
   localparam int DIV_W = 16;
   localparam int DEPTH = 8;
   localparam int LVL_W = $clog2(DEPTH+1);

   logic             clk = 1'b0, rst = 1'b1, en = 1'b0, rx = 1'b1, rdy = 1'b1, ovr_clr = 1'b0;
   logic [DIV_W-1:0] baud_div = 16'd3;
   logic [1:0]       cfg_dbits = 2'd3, cfg_par = 2'd0;
   logic             cfg_stop2 = 1'b0;
   logic [7:0]       o_data;
   logic [2:0]       o_err;
   logic             o_valid, o_overrun, o_busy;
   logic [LVL_W-1:0] o_level;

   always #5 clk = ~clk;

   uart_rx_core #(.OVS(OVS), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_rx_en(en), .i_baud_div(baud_div),
      .i_cfg_dbits(cfg_dbits), .i_cfg_parity(cfg_par), .i_cfg_stop2(cfg_stop2),
      .i_uart_rx(rx), .o_data(o_data), .o_err(o_err), .o_valid(o_valid),
      .i_ready(rdy), .o_level(o_level), .o_overrun(o_overrun),
      .i_overrun_clr(ovr_clr), .o_busy(o_busy));

   typedef struct { logic [7:0] d; logic [2:0] e; } ent_t;
   ent_t sb[$];

   int n_tests = 0, n_fail = 0, extra_pops = 0, peak = 0, div = 3;
   bit busy_seen = 0, exp_ovr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int bp();
      return OVS * (div + 1);
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Consumer-side scoreboard: every pop must match the oldest expected entry.
   initial forever begin
      @(negedge clk);
      if (int'(o_level) > peak) peak = int'(o_level);
      if (o_busy) busy_seen = 1;
      if (o_valid && rdy && !rst) begin
         if (sb.size() == 0) extra_pops++;
         else begin
            ent_t e;
            e = sb.pop_front();
            chk("rx_data", {24'd0, o_data}, {24'd0, e.d});
            chk("rx_err", {29'd0, o_err}, {29'd0, e.e});
         end
      end
   end

   // Sends one frame and records what a correct receiver must deliver.
   task automatic send_frame(input logic [7:0] d, input int nb, input int par, input bit stop2,
                             input bit bad_par, input bit bad_s1, input bit bad_s2);
      logic [7:0] dm;
      bit pen, pbit, s1, s2, brk, frm;
      ent_t e;
      dm   = d & 8'((1 << nb) - 1);
      pen  = (par == 1) || (par == 2);
      pbit = (par == 1) ? ^dm : ~^dm;
      if (bad_par) pbit = ~pbit;
      s1   = !bad_s1;
      s2   = !bad_s2;
      brk  = (dm == 8'd0) && (!pen || !pbit) && !s1;
      frm  = !s1 || (stop2 && !s2);
      e.d  = dm;
      e.e  = {brk, frm, pen && bad_par};
      if (sb.size() < DEPTH) sb.push_back(e);
      else exp_ovr = 1;
      cfg_dbits = 2'(nb - 5);
      cfg_par   = 2'(par);
      cfg_stop2 = stop2;
      rx = 1'b0; wait_clk(bp());
      for (int i = 0; i < nb; i++) begin rx = dm[i]; wait_clk(bp()); end
      if (pen) begin rx = pbit; wait_clk(bp()); end
      rx = s1; wait_clk(bp());
      if (stop2) begin rx = s2; wait_clk(bp()); end
      rx = 1'b1; wait_clk(2 * bp());
   endtask

   task automatic partial_8n1();
      cfg_dbits = 2'd3; cfg_par = 2'd0; cfg_stop2 = 1'b0;
      rx = 1'b0; wait_clk(bp());
      rx = 1'b1; wait_clk(bp());
      rx = 1'b0; wait_clk(bp());
      rx = 1'b1; wait_clk(bp() / 2);
   endtask

   initial begin
      wait_clk(3);
      // reset state
      chk("rst_valid", {31'd0, o_valid}, 0);
      chk("rst_err", {29'd0, o_err}, 0);
      chk("rst_data", {24'd0, o_data}, 0);
      chk("rst_level", {28'd0, o_level}, 0);
      chk("rst_overrun", {31'd0, o_overrun}, 0);
      chk("rst_busy", {31'd0, o_busy}, 0);
      rst = 1'b0; en = 1'b1; wait_clk(10);

      // 8N1 basic, ready held high
      peak = 0;
      send_frame(8'hA5, 8, 0, 0, 0, 0, 0);
      send_frame(8'h3C, 8, 0, 0, 0, 0, 0);
      chk("8n1_peak", peak, 1);
      chk("8n1_drained", sb.size(), 0);

      // 7O2 good then bad parity
      send_frame(8'h55, 7, 2, 1, 0, 0, 0);
      send_frame(8'h55, 7, 2, 1, 1, 0, 0);
      chk("7o2_drained", sb.size(), 0);

      // framing error, then break
      send_frame(8'h41, 8, 0, 0, 0, 1, 0);
      begin
         ent_t e; e.d = 8'h00; e.e = 3'b110; sb.push_back(e);
      end
      cfg_dbits = 2'd3; cfg_par = 2'd0; cfg_stop2 = 1'b0;
      rx = 1'b0; wait_clk(20 * bp());
      chk("brk_wait_busy", {31'd0, o_busy}, 1);
      chk("brk_single", sb.size(), 0);
      chk("brk_level", {28'd0, o_level}, 0);
      rx = 1'b1; wait_clk(2 * bp());
      chk("brk_idle", {31'd0, o_busy}, 0);

      // short glitch on idle line
      busy_seen = 0;
      rx = 1'b0; wait_clk(bp() * 3 / 10);
      rx = 1'b1; wait_clk(2 * bp());
      chk("glitch_busy_seen", {31'd0, busy_seen}, 1);
      chk("glitch_idle", {31'd0, o_busy}, 0);
      chk("glitch_level", {28'd0, o_level}, 0);

      // overrun with consumer stalled
      rdy = 1'b0; exp_ovr = 0;
      for (int k = 0; k < 9; k++) send_frame(8'($urandom), 8, 0, 0, 0, 0, 0);
      chk("ovr_level", {28'd0, o_level}, DEPTH);
      chk("ovr_flag", {31'd0, o_overrun}, {31'd0, exp_ovr});
      chk("ovr_head_data", {24'd0, o_data}, {24'd0, sb[0].d});
      chk("ovr_head_err", {29'd0, o_err}, {29'd0, sb[0].e});
      ovr_clr = 1'b1; wait_clk(1); ovr_clr = 1'b0;
      chk("ovr_clr", {31'd0, o_overrun}, 0);
      rdy = 1'b1; wait_clk(20);
      chk("ovr_drain_level", {28'd0, o_level}, 0);
      chk("ovr_drain_sb", sb.size(), 0);

      // enable dropped mid-data
      partial_8n1();
      chk("abort_en_pre", {31'd0, o_busy}, 1);
      en = 1'b0; wait_clk(1);
      chk("abort_en_busy", {31'd0, o_busy}, 0);
      rx = 1'b1; wait_clk(3 * bp());
      chk("abort_en_level", {28'd0, o_level}, 0);
      en = 1'b1; wait_clk(bp());
      send_frame(8'h7E, 8, 0, 0, 0, 0, 0);
      chk("abort_en_next", sb.size(), 0);

      // reset mid-data
      partial_8n1();
      chk("abort_rst_pre", {31'd0, o_busy}, 1);
      rst = 1'b1; rx = 1'b1; wait_clk(2);
      chk("abort_rst_busy", {31'd0, o_busy}, 0);
      chk("abort_rst_level", {28'd0, o_level}, 0);
      rst = 1'b0; wait_clk(bp());
      send_frame(8'h7E, 8, 0, 0, 0, 0, 0);
      chk("abort_rst_next", sb.size(), 0);

      // randomized formats, errors and dividers
      for (int k = 0; k < 20; k++) begin
         logic [7:0] d;
         div      = int'($urandom_range(1, 4));
         baud_div = DIV_W'(div);
         wait_clk(bp());
         d = 8'($urandom);
         if ($urandom_range(0, 5) == 0) d = 8'h00;
         send_frame(d, int'($urandom_range(5, 8)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      end
      wait_clk(20);
      chk("final_sb_empty", sb.size(), 0);
      chk("final_extra_pops", extra_pops, 0);
      chk("final_overrun", {31'd0, o_overrun}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
